lsu_subword: RTL and testbench
==============================

// Module: lsu_subword
// PURPOSE
//  Load/store unit between the MEM-stage datapath and the word-only dmem.
//  - Byte/halfword/word loads: lane select, sign/zero extension.
//  - Sub-word stores: 2-cycle read-modify-write over the 32-bit dmem port.
//  - Upstream side: valid/ready request handshake and a registered response.
// PARAMETERS
//  n  32  data/address width; must be 32 (4 byte lanes)
// PORTS
//  clk             in   1  clock, rising edge
//  reset_n         in   1  asynchronous, active-low reset
//  req_valid       in   1  request present
//  req_ready       out  1  LSU can accept a request this cycle
//  req_write       in   1  1=store, 0=load
//  req_size        in   2  00=byte, 01=half, 10=word, 11=treated as word
//  req_unsigned    in   1  loads only: 1=zero-extend, 0=sign-extend
//  req_addr        in   n  byte address
//  req_wdata       in   n  store data, right-justified
//  resp_valid      out  1  one-cycle pulse: request completed
//  resp_rdata      out  n  load result, valid with resp_valid (0 for stores)
//  resp_err        out  1  misaligned request, valid with resp_valid (MISALIGN_TRAP_EN only)
//  mem_write_enable out 1  to dmem write_enable
//  mem_addr        out  n  to dmem addr; bits [1:0] always 0
//  mem_writedata   out  n  to dmem writedata
//  mem_readdata    in   n  from dmem readdata (combinational read)
// BEHAVIOUR
//  - Reset: state=IDLE. resp_valid=0, resp_rdata=0, resp_err=0. Write enable deasserts immediately.
//  - Reset also clears the captured address/data registers.
//  - Accept = req_valid & req_ready. No request is dropped while req_ready=0.
//  - States:
//    - IDLE: req_ready=1.
//    - RMW_WR: req_ready=0.
//  - Load (IDLE, accept):
//    - mem_addr={req_addr[n-1:2],2'b00}. Lane extracted from mem_readdata the same cycle and registered.
//    - resp_valid=1 the next cycle. State stays IDLE. Latency 1; back-to-back at 1/cycle.
//  - Lane select is little-endian:
//    - byte: lane = addr[1:0].
//    - half: lane = addr[1] (bits [15:0] or [31:16]).
//    - Extension per req_unsigned.
//  - Word store (accept): mem_write_enable=1 combinationally in the accept cycle.
//    - mem_writedata=req_wdata. Write occurs at that edge.
//    - resp_valid next cycle. State stays IDLE.
//  - Sub-word store (accept):
//    - Read the word at the aligned address the same cycle.
//    - Register the merged word (target lane(s) replaced by req_wdata low bits) and the aligned address.
//    - Go to RMW_WR.
//  - RMW_WR: mem_write_enable=1, registered mem_addr/mem_writedata. Return to IDLE.
//    - resp_valid pulses the cycle after RMW_WR. Latency 2; throughput 1 per 2 cycles.
//  - mem_write_enable is 0 in all other cycles. In IDLE with no accept, mem_addr=aligned req_addr.
//  - Store after store to the same word: the second RMW reads the already-updated dmem.
//    - No forwarding is needed because the write completes before the next accept.
//  - Reset mid-RMW (reset_n low in RMW_WR): write abandoned, memory word unchanged.
//    - No resp_valid is issued for the abandoned request.
//  - Address wrap: word index is addr[n-1:2] unmodified. Out-of-range behaviour is dmem's.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//  - half with addr[0]=1, or word with addr[1:0]!=0: no dmem access, mem_write_enable stays 0.
//  - resp_valid next cycle with resp_err=1, resp_rdata=0.
//  MISALIGN_TRAP_EN undefined:
//  - Offending low address bits are ignored (half uses addr[1], word uses addr[1:0]=00).
//  - The access proceeds normally. resp_err is tied to 0.
// TESTING
//  1. Reset: reset_n=0 mid-cycle -> all outputs 0 asynchronously, req_ready=1 after release.
//  2. Word load: preload word 1=0x8899AABB; LB addr 0x5 -> 0xFFFFFFAA; LBU 0x5 -> 0x000000AA;
//     LH 0x6 -> 0xFFFF8899. Each resp_valid 1 cycle after accept.
//  3. Word store: SW 0xDEADBEEF @0x8 -> write in accept cycle; LW 0x8 -> 0xDEADBEEF;
//     req_ready never drops.
//  4. Sub-word RMW: word 0x11223344 @0xC; SB 0x55 @0xE -> req_ready=0 one cycle, write 0x11553344.
//     Then SH 0xABCD @0xC -> 0x1155ABCD.
//  5. Reset in RMW_WR: SB @0x10, assert reset_n=0 during RMW_WR -> word @0x10 unchanged,
//     no resp_valid.
//  6. Misaligned SH @0x3:
//     - MISALIGN_TRAP_EN -> resp_err=1, memory untouched.
//     - Without it -> writes upper half of word @0x0.

Source files
------------

// File: rtl/lsu_subword.sv
// Load/store unit between the MEM stage and a word-only dmem: sub-word loads with extension,
// sub-word stores as a 2-cycle read-modify-write. Optional macro MISALIGN_TRAP_EN reports misaligned accesses.
module lsu_subword #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         resp_valid,
    output logic [n-1:0] resp_rdata,
    output logic         resp_err,
    output logic         mem_write_enable,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_writedata,
    input  logic [n-1:0] mem_readdata
);

    typedef enum logic [0:0] {IDLE, RMW_WR} state_t;

    state_t       state_q, state_d;
    logic         resp_valid_q, resp_valid_d;
    logic [n-1:0] resp_rdata_q, resp_rdata_d;
    logic         resp_err_q, resp_err_d;
    logic [n-1:0] wr_addr_q, wr_addr_d;
    logic [n-1:0] wr_data_q, wr_data_d;

    logic         accept;
    logic         is_word;
    logic         misaligned;
    logic [n-1:0] aligned_addr;
    logic [7:0]   lane_byte;
    logic [15:0]  lane_half;
    logic [n-1:0] load_val;
    logic [n-1:0] merged;

    assign is_word      = req_size[1];
    assign aligned_addr = {req_addr[n-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Little-endian lane extraction and merge; halfword lane ignores addr[0].
    always_comb begin
        lane_byte = mem_readdata[{req_addr[1:0], 3'b000} +: 8];
        lane_half = mem_readdata[{req_addr[1], 4'b0000} +: 16];
        case (req_size)
            2'b00:   load_val = {{(n-8){~req_unsigned & lane_byte[7]}}, lane_byte};
            2'b01:   load_val = {{(n-16){~req_unsigned & lane_half[15]}}, lane_half};
            default: load_val = mem_readdata;
        endcase
        merged = mem_readdata;
        if (req_size == 2'b00) begin
            merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        end else begin
            merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
        end
    end

    assign accept = req_valid & req_ready;

    always_comb begin
        state_d          = state_q;
        resp_valid_d     = 1'b0;
        resp_rdata_d     = '0;
        resp_err_d       = 1'b0;
        wr_addr_d        = wr_addr_q;
        wr_data_d        = wr_data_q;
        req_ready        = 1'b0;
        mem_write_enable = 1'b0;
        mem_addr         = aligned_addr;
        mem_writedata    = req_wdata;
        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so nothing is accepted or written.
                req_ready = reset_n;
                if (accept) begin
                    resp_valid_d = 1'b1;
                    if (misaligned) begin
                        resp_err_d = 1'b1;
                    end else if (req_write) begin
                        if (is_word) begin
                            mem_write_enable = 1'b1;
                        end else begin
                            wr_addr_d    = aligned_addr;
                            wr_data_d    = merged;
                            resp_valid_d = 1'b0;
                            state_d      = RMW_WR;
                        end
                    end else begin
                        resp_rdata_d = load_val;
                    end
                end
            end
            RMW_WR: begin
                mem_write_enable = 1'b1;
                mem_addr         = wr_addr_q;
                mem_writedata    = wr_data_q;
                resp_valid_d     = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_subword.sv
// Bench for lsu_subword: directed steps plus random traffic against an arithmetic reference
// memory model; a word-only dmem model sits on the memory port.
module tb_lsu_subword;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_write_enable;
    logic [31:0] mem_addr, mem_writedata, mem_readdata;

    logic [31:0] dmem    [0:63];
    logic [31:0] ref_mem [0:63];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_subword #(.n(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    assign mem_readdata = dmem[mem_addr[7:2]];
    always @(posedge clk) if (mem_write_enable) dmem[mem_addr[7:2]] <= mem_writedata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_mis(input int size, input int addr);
`ifdef MISALIGN_TRAP_EN
        return (size == 1 && addr % 2 != 0) || (size >= 2 && addr % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int size, input bit uns, input int addr);
        logic [31:0] v;
        int off;
        if (size == 0) begin
            off = addr % 4;
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (size == 1) begin
            off = ((addr % 4) / 2) * 2;
            v = (w >> (8 * off)) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input int size, input int addr, input logic [31:0] d);
        logic [31:0] mask;
        int off;
        if (size >= 2) return d;
        off  = (size == 0) ? addr % 4 : ((addr % 4) / 2) * 2;
        mask = ((size == 0) ? 32'hFF : 32'hFFFF) << (8 * off);
        return (w & ~mask) | ((d << (8 * off)) & mask);
    endfunction

    // One request from an idle cycle: checks accept cycle, optional RMW cycle and the response.
    task automatic do_req(input string tag, input bit wr, input int size, input bit uns,
                          input int addr, input logic [31:0] wdata);
        int          idx = (addr / 4) % 64;
        bit          mis = ref_mis(size, addr);
        bit          sw  = wr && !mis && size >= 2;
        bit          rmw = wr && !mis && size < 2;
        logic [31:0] old_w = ref_mem[idx];
        logic [31:0] new_w = ref_store(old_w, size, addr, wdata);
        logic [31:0] exp_r = (wr || mis) ? 32'h0 : ref_load(old_w, size, uns, addr);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = 2'(size); req_unsigned = uns;
        req_addr = 32'(addr); req_wdata = wdata;
        #1;
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        check({tag, ".idle_resp"}, 32'(resp_valid), 32'd0);
        check({tag, ".we_acc"}, 32'(mem_write_enable), 32'(sw));
        if (!mis) check({tag, ".addr_acc"}, mem_addr, 32'(addr) & 32'hFFFFFFFC);
        if (sw) check({tag, ".wdata_acc"}, mem_writedata, wdata);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        if (rmw) begin
            check({tag, ".rmw_ready"}, 32'(req_ready), 32'd0);
            check({tag, ".rmw_we"}, 32'(mem_write_enable), 32'd1);
            check({tag, ".rmw_addr"}, mem_addr, 32'(addr) & 32'hFFFFFFFC);
            check({tag, ".rmw_data"}, mem_writedata, new_w);
            check({tag, ".rmw_resp"}, 32'(resp_valid), 32'd0);
            @(negedge clk);
            #1;
        end
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".rdata"}, resp_rdata, exp_r);
        check({tag, ".err"}, 32'(resp_err), 32'(mis));
        if (wr && !mis) ref_mem[idx] = new_w;
        $display("req %s wr=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
                 tag, wr, size, uns, addr, wdata, resp_rdata, resp_err);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        check("rst.err", 32'(resp_err), 32'd0);
        check("rst.we", 32'(mem_write_enable), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst.ready_after", 32'(req_ready), 32'd1);

        for (int i = 0; i < 64; i++) do_req("pre", 1'b1, 2, 1'b0, i * 4, $urandom);

        do_req("sw_w1", 1'b1, 2, 1'b0, 32'h4, 32'h8899AABB);
        do_req("lb", 1'b0, 0, 1'b0, 32'h5, 32'h0);
        do_req("lbu", 1'b0, 0, 1'b1, 32'h5, 32'h0);
        do_req("lh", 1'b0, 1, 1'b0, 32'h6, 32'h0);
        do_req("sw", 1'b1, 2, 1'b0, 32'h8, 32'hDEADBEEF);
        do_req("lw", 1'b0, 2, 1'b0, 32'h8, 32'h0);
        do_req("sw_c", 1'b1, 2, 1'b0, 32'hC, 32'h11223344);
        do_req("sb", 1'b1, 0, 1'b0, 32'hE, 32'h55);
        do_req("sh", 1'b1, 1, 1'b0, 32'hC, 32'hABCD);
        do_req("lw_c", 1'b0, 2, 1'b0, 32'hC, 32'h0);
        check("rmw.word_c", ref_mem[3], 32'h1155ABCD);
        check("rmw.dmem_c", dmem[3], 32'h1155ABCD);

        // Back-to-back loads, one per cycle.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h8;
        @(negedge clk);
        req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'hD;
        #1;
        check("b2b.ready", 32'(req_ready), 32'd1);
        check("b2b.v1", 32'(resp_valid), 32'd1);
        check("b2b.d1", resp_rdata, ref_load(ref_mem[2], 2, 1'b0, 8));
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("b2b.v2", 32'(resp_valid), 32'd1);
        check("b2b.d2", resp_rdata, ref_load(ref_mem[3], 0, 1'b1, 13));
        $display("req b2b lw 0x8 / lbu 0xD");

        // Asynchronous reset in the middle of a cycle while a response is showing.
        #2;
        reset_n = 1'b0;
        #1;
        check("arst.resp_valid", 32'(resp_valid), 32'd0);
        check("arst.rdata", resp_rdata, 32'd0);
        check("arst.ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("arst.ready_after", 32'(req_ready), 32'd1);

        // Reset during RMW_WR: the store is dropped.
        do_req("sw_10", 1'b1, 2, 1'b0, 32'h10, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h77;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("abort.we_rmw", 32'(mem_write_enable), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort.we_off", 32'(mem_write_enable), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("abort.dmem", dmem[4], 32'hCAFEF00D);
        check("abort.no_resp1", 32'(resp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("abort.no_resp2", 32'(resp_valid), 32'd0);
        $display("req abort sb @0x10 -> dmem=%h", dmem[4]);
        do_req("lw_10", 1'b0, 2, 1'b0, 32'h10, 32'h0);

        do_req("sh_mis", 1'b1, 1, 1'b0, 32'h3, 32'h1234);
        do_req("lw_0", 1'b0, 2, 1'b0, 32'h0, 32'h0);
        check("mis.dmem0", dmem[0], ref_mem[0]);

        for (int i = 0; i < 300; i++)
            do_req("rnd", 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                   int'($urandom_range(0, 255)), $urandom);
        for (int i = 0; i < 64; i++) check("final.dmem", dmem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
